uart_sdram_bridge: RTL and testbench

Parametrised UART-to-SDRAM command bridge for board-level testing of sdram_ctrl. It replaces single-byte read/write debug logic with multi-byte addresses, full-width data words, burst transfers and status replies. It sits between the uart byte interface and the sdram_ctrl request interface, all in the dram_clk domain.

---
 rtl/uart_sdram_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_sdram_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sdram_bridge.sv
// uart_sdram_bridge: turns UART command frames into sdram_ctrl write/read requests and sends status/data replies.
// Latency: o_rx_req follows i_rx_rdy combinationally; o_wr_req can fire one cycle after the last data byte is latched.
// Backpressure: a request waits for i_ctrl_rdy, a reply byte waits for i_tx_rdy, and a read waits for i_rd_rdy up to TimeoutCycles.
// Ports: dram_clk/i_rst_n (sync, active-low); UART rx (i_rx_data/i_rx_rdy/o_rx_req),
//        UART tx (o_tx_data/o_tx_req/i_tx_rdy); sdram_ctrl (i_ctrl_rdy, o_wr_*, o_rd_*, i_rd_*);
//        status (o_busy, o_err_count).
module uart_sdram_bridge #(
  parameter int AddrWidth     = 22,
  parameter int DataWidth     = 16,
  parameter int AddrBytes     = 3,
  parameter int DataBytes     = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 dram_clk,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_rdy,
  output logic                 o_rx_req,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_req,
  input  logic                 i_tx_rdy,
  input  logic                 i_ctrl_rdy,
  output logic                 o_wr_req,
  output logic [AddrWidth-1:0] o_wr_addr,
  output logic [DataWidth-1:0] o_wr_data,
  output logic                 o_rd_req,
  output logic [AddrWidth-1:0] o_rd_addr,
  input  logic [DataWidth-1:0] i_rd_data,
  input  logic                 i_rd_rdy,
  output logic                 o_busy,
  output logic [7:0]           o_err_count
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GET_LEN  = 4'd1;
  localparam logic [3:0] S_GET_ADDR = 4'd2;
  localparam logic [3:0] S_GET_DATA = 4'd3;
  localparam logic [3:0] S_WR_ISSUE = 4'd4;
  localparam logic [3:0] S_RD_ISSUE = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_TX_DATA  = 4'd7;
  localparam logic [3:0] S_TX_RESP  = 4'd8;

  localparam int TmoW = $clog2(TimeoutCycles) + 1;

  logic [3:0]             r_state;
  logic                   r_is_wr;
  logic [8:0]             r_count;      // words left in burst, 1..256
  logic [7:0]             r_byte_cnt;   // byte index within address/data field
  logic [AddrWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_data;
  logic [AddrWidth-1:0]   r_wr_addr;
  logic [DataWidth-1:0]   r_wr_data;
  logic [DataWidth-1:0]   r_rd_data;
  logic [TmoW-1:0]        r_tmo;
  logic [7:0]             r_err_count;
  logic [7:0]             r_reply;
  logic                   r_rx_prev;    // o_rx_req was high last cycle
  logic                   r_tx_wait;    // one idle cycle after each tx request

  logic                   w_rx_state;
  logic                   w_rx_take;
  logic                   w_tx_state;
  logic                   w_tx_req;
  logic                   w_wr_req;
  logic                   w_rd_req;
  logic [AddrWidth-1:0]   w_addr_shift;
  logic [DataWidth-1:0]   w_data_shift;
  logic [DataBytes*8-1:0] w_rd_ext;
  logic [7:0]             w_tx_idx;
  logic [7:0]             w_tx_byte;
  logic                   w_tmo_hit;

  assign w_rx_state = (r_state == S_IDLE) || (r_state == S_GET_LEN) ||
                      (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
  assign w_rx_take  = i_rst_n && w_rx_state && i_rx_rdy && !r_rx_prev;

  assign w_tx_state = (r_state == S_TX_DATA) || (r_state == S_TX_RESP);
  assign w_tx_req   = i_rst_n && w_tx_state && i_tx_rdy && !r_tx_wait;

  // Requests are combinational on i_ctrl_rdy so a pulse only ever appears while it is high.
  assign w_wr_req   = i_rst_n && (r_state == S_WR_ISSUE) && i_ctrl_rdy;
  assign w_rd_req   = i_rst_n && (r_state == S_RD_ISSUE) && i_ctrl_rdy;

  // Shift in a byte, keeping only the low bits that fit the field.
  assign w_addr_shift = AddrWidth'({r_addr, i_rx_data});
  assign w_data_shift = DataWidth'({r_data, i_rx_data});

  // Read reply bytes go out MSB first from the zero-extended word.
  assign w_rd_ext  = (DataBytes*8)'(r_rd_data);
  assign w_tx_idx  = 8'(DataBytes - 1) - r_byte_cnt;
  assign w_tx_byte = (r_state == S_TX_RESP) ? r_reply : w_rd_ext[{w_tx_idx, 3'b000} +: 8];

  // r_tmo is zero in the first RD_WAIT cycle, so hitting TimeoutCycles-2 here puts the
  // 'T' reply on the wire exactly TimeoutCycles cycles after the read request.
  assign w_tmo_hit = (r_tmo == TmoW'(TimeoutCycles - 2));

  assign o_rx_req    = w_rx_take;
  assign o_tx_req    = w_tx_req;
  assign o_tx_data   = w_tx_req ? w_tx_byte : 8'h00;
  assign o_wr_req    = w_wr_req;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_rd_req    = w_rd_req;
  assign o_rd_addr   = r_addr;
  assign o_busy      = (r_state != S_IDLE);
  assign o_err_count = r_err_count;

  always_ff @(posedge dram_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_is_wr     <= 1'b0;
      r_count     <= '0;
      r_byte_cnt  <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_data   <= '0;
      r_tmo       <= '0;
      r_err_count <= '0;
      r_reply     <= '0;
      r_rx_prev   <= 1'b0;
      r_tx_wait   <= 1'b0;
    end else begin
      r_rx_prev <= w_rx_take;
      r_tx_wait <= w_tx_req;
      case (r_state)
        S_IDLE: begin
          if (w_rx_take) begin
            if (i_rx_data == 8'h77 || i_rx_data == 8'h72) begin
              r_is_wr <= (i_rx_data == 8'h77);
              r_state <= S_GET_LEN;
            end else begin
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
              r_reply <= 8'h45;
              r_state <= S_TX_RESP;
            end
          end
        end
        S_GET_LEN: begin
          if (w_rx_take) begin
            r_count    <= {(i_rx_data == 8'h00), i_rx_data};
            r_byte_cnt <= '0;
            r_state    <= S_GET_ADDR;
          end
        end
        S_GET_ADDR: begin
          if (w_rx_take) begin
            r_addr <= w_addr_shift;
            if (r_byte_cnt == 8'(AddrBytes - 1)) begin
              r_byte_cnt <= '0;
              r_state    <= r_is_wr ? S_GET_DATA : S_RD_ISSUE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end
        end
        S_GET_DATA: begin
          if (w_rx_take) begin
            r_data <= w_data_shift;
            if (r_byte_cnt == 8'(DataBytes - 1)) begin
              r_byte_cnt <= '0;
              // Load the request registers now so they are valid during WR_ISSUE
              // and hold until the next word is complete.
              r_wr_addr  <= r_addr;
              r_wr_data  <= w_data_shift;
              r_state    <= S_WR_ISSUE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end
        end
        S_WR_ISSUE: begin
          if (w_wr_req) begin
            r_addr  <= r_addr + AddrWidth'(1);
            r_count <= r_count - 9'd1;
            if (r_count == 9'd1) begin
              r_reply <= 8'h4B;
              r_state <= S_TX_RESP;
            end else begin
              r_state <= S_GET_DATA;
            end
          end
        end
        S_RD_ISSUE: begin
          if (w_rd_req) begin
            r_tmo   <= '0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (i_rd_rdy) begin
            r_rd_data  <= i_rd_data;
            r_byte_cnt <= '0;
            r_state    <= S_TX_DATA;
          end else if (w_tmo_hit) begin
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            r_reply <= 8'h54;
            r_state <= S_TX_RESP;
          end else begin
            r_tmo <= r_tmo + TmoW'(1);
          end
        end
        S_TX_DATA: begin
          if (w_tx_req) begin
            if (r_byte_cnt == 8'(DataBytes - 1)) begin
              r_byte_cnt <= '0;
              r_addr     <= r_addr + AddrWidth'(1);
              r_count    <= r_count - 9'd1;
              r_state    <= (r_count == 9'd1) ? S_IDLE : S_RD_ISSUE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end
        end
        S_TX_RESP: begin
          if (w_tx_req) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sdram_bridge.sv
// Directed bench for uart_sdram_bridge with queue-based scoreboard.
// Stimulus pushes expected tx bytes, write and read requests; a monitor pops and compares.
// Clock 10 ns; outputs sampled 2 ns after the falling edge.
module tb_uart_sdram_bridge;
  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int TMO = 1024;

  logic          dram_clk = 1'b0;
  logic          i_rst_n;
  logic [7:0]    i_rx_data;
  logic          i_rx_rdy;
  logic          o_rx_req;
  logic [7:0]    o_tx_data;
  logic          o_tx_req;
  logic          i_tx_rdy;
  logic          i_ctrl_rdy;
  logic          o_wr_req;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_rd_req;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic          i_rd_rdy;
  logic          o_busy;
  logic [7:0]    o_err_count;

  uart_sdram_bridge #(.AddrWidth(AW), .DataWidth(DW), .AddrBytes(3), .DataBytes(2),
                      .TimeoutCycles(TMO)) dut (
    .dram_clk(dram_clk), .i_rst_n(i_rst_n),
    .i_rx_data(i_rx_data), .i_rx_rdy(i_rx_rdy), .o_rx_req(o_rx_req),
    .o_tx_data(o_tx_data), .o_tx_req(o_tx_req), .i_tx_rdy(i_tx_rdy),
    .i_ctrl_rdy(i_ctrl_rdy),
    .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data), .i_rd_rdy(i_rd_rdy),
    .o_busy(o_busy), .o_err_count(o_err_count)
  );

  always #5 dram_clk = ~dram_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  logic [7:0]    exp_tx[$];
  logic [AW-1:0] exp_wr_addr[$];
  logic [DW-1:0] exp_wr_data[$];
  logic [AW-1:0] exp_rd[$];
  logic [DW-1:0] rd_data_q[$];
  logic          rd_en = 1'b1;
  logic          ctrl_toggle = 1'b0;
  logic [7:0]    exp_err = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge dram_clk) cyc <= cyc + 1;

  // Scoreboard monitor
  initial forever begin
    @(negedge dram_clk); #2;
    if (o_wr_req || o_rd_req) chk("wr_rd_exclusive", {o_wr_req, o_rd_req} == 2'b11, 0);
    if (o_tx_req) begin
      chk("tx_rdy_gate", i_tx_rdy, 1);
      if (exp_tx.size() == 0) chk("tx_unexpected", o_tx_data, 32'hFFFF_FFFF);
      else begin
        logic [7:0] e;
        e = exp_tx.pop_front();
        chk("tx_byte", o_tx_data, e);
        if (e == 8'h54) chk("timeout_latency", cyc - last_rd_cyc, TMO);
      end
    end
    if (o_wr_req) begin
      chk("wr_ctrl_rdy", i_ctrl_rdy, 1);
      if (exp_wr_addr.size() == 0) chk("wr_unexpected", o_wr_addr, 32'hFFFF_FFFF);
      else begin
        chk("wr_addr", o_wr_addr, exp_wr_addr.pop_front());
        chk("wr_data", o_wr_data, exp_wr_data.pop_front());
      end
    end
    if (o_rd_req) begin
      last_rd_cyc = cyc;
      if (exp_rd.size() == 0) chk("rd_unexpected", o_rd_addr, 32'hFFFF_FFFF);
      else chk("rd_addr", o_rd_addr, exp_rd.pop_front());
    end
  end

  // Read-data responder: answers each read three cycles later when enabled.
  initial forever begin
    @(negedge dram_clk); #2;
    if (o_rd_req && rd_en && rd_data_q.size() > 0) begin
      repeat (3) @(negedge dram_clk);
      i_rd_data = rd_data_q.pop_front();
      i_rd_rdy  = 1'b1;
      @(negedge dram_clk);
      i_rd_rdy  = 1'b0;
    end
  end

  // Optional i_ctrl_rdy toggling every other cycle.
  initial forever begin
    @(negedge dram_clk);
    if (ctrl_toggle) i_ctrl_rdy = ~i_ctrl_rdy;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge dram_clk);
    i_rx_data = b;
    i_rx_rdy  = 1'b1;
    #1;
    while (!o_rx_req && n < 3000) begin
      @(negedge dram_clk); #1; n++;
    end
    if (!o_rx_req) chk("rx_consume_timeout", 0, 1);
    @(posedge dram_clk); #1;
    i_rx_rdy = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_tx.size() + exp_wr_addr.size() + exp_rd.size()) != 0 && n < limit) begin
      @(negedge dram_clk); n++;
    end
    chk("drain_pending", exp_tx.size() + exp_wr_addr.size() + exp_rd.size(), 0);
    repeat (4) @(negedge dram_clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_err"}, o_err_count, 0);
    chk({tag, "_strobes"}, {o_rx_req, o_tx_req, o_wr_req, o_rd_req}, 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_wr_addr"}, o_wr_addr, 0);
    chk({tag, "_wr_data"}, o_wr_data, 0);
    chk({tag, "_rd_addr"}, o_rd_addr, 0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_rx_data = 8'h00; i_rx_rdy = 1'b0; i_tx_rdy = 1'b1;
    i_ctrl_rdy = 1'b1; i_rd_data = '0; i_rd_rdy = 1'b0;
    repeat (3) @(posedge dram_clk);
    @(negedge dram_clk); #2;
    check_all_zero("reset");
    i_rst_n = 1'b1;

    // Single write
    exp_wr_addr.push_back(22'h001234); exp_wr_data.push_back(16'hABCD);
    exp_tx.push_back(8'h4B);
    send_byte(8'h77); send_byte(8'h01); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    drain(200);

    // Burst read across the top of the address space
    rd_data_q.push_back(16'h1111); rd_data_q.push_back(16'h2222); rd_data_q.push_back(16'h3333);
    exp_rd.push_back(22'h3FFFFF); exp_rd.push_back(22'h000000); exp_rd.push_back(22'h000001);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h22); exp_tx.push_back(8'h33); exp_tx.push_back(8'h33);
    send_byte(8'h72); send_byte(8'h03); send_byte(8'h3F); send_byte(8'hFF); send_byte(8'hFF);
    drain(300);
    chk("busy_after_read", o_busy, 0);

    // Invalid command
    exp_tx.push_back(8'h45); exp_err = exp_err + 8'd1;
    send_byte(8'h41);
    drain(100);
    chk("err_count_invalid", o_err_count, exp_err);

    // Invalid command with transmitter held busy
    i_tx_rdy = 1'b0;
    exp_tx.push_back(8'h45); exp_err = exp_err + 8'd1;
    send_byte(8'h41);
    repeat (50) @(negedge dram_clk);
    chk("tx_held_off", exp_tx.size(), 1);
    chk("busy_while_held", o_busy, 1);
    i_tx_rdy = 1'b1;
    drain(100);
    chk("err_count_backpressure", o_err_count, exp_err);

    // Read timeout: no data returned, remaining word dropped
    rd_en = 1'b0;
    exp_rd.push_back(22'h000010);
    exp_tx.push_back(8'h54); exp_err = exp_err + 8'd1;
    send_byte(8'h72); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    drain(TMO + 200);
    repeat (200) @(negedge dram_clk);
    chk("err_count_timeout", o_err_count, exp_err);
    chk("busy_after_timeout", o_busy, 0);
    rd_en = 1'b1;

    // 256-word write with i_ctrl_rdy toggling
    ctrl_toggle = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_wr_addr.push_back(AW'(22'h000100 + i));
      exp_wr_data.push_back(DW'(16'h5A00 ^ i));
    end
    exp_tx.push_back(8'h4B);
    send_byte(8'h77); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'h5A00 ^ 16'(i);
      send_byte(w[15:8]); send_byte(w[7:0]);
    end
    drain(500);
    ctrl_toggle = 1'b0;
    i_ctrl_rdy = 1'b1;

    // Reset during the second word of a 4-word write
    exp_wr_addr.push_back(22'h000020); exp_wr_data.push_back(16'hAAAA);
    send_byte(8'h77); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge dram_clk);
    i_rst_n = 1'b0;
    @(posedge dram_clk);
    @(negedge dram_clk); #2;
    check_all_zero("midreset");
    chk("midreset_word1_written", exp_wr_addr.size(), 0);
    @(negedge dram_clk);
    i_rst_n = 1'b1;
    exp_err = 8'd0;

    // Read after reset
    rd_data_q.push_back(16'hBEEF);
    exp_rd.push_back(22'h000005);
    exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
    send_byte(8'h72); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
    drain(300);
    chk("err_after_reset", o_err_count, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule
